// File: rtl/seq_mul.sv
// ----------------------------------------------------------------------------
// seq_mul -- sequential shift-and-add multiplier.
//
// Handles one multiplier bit per clock, so every multiply spends exactly
// WIDTH cycles in RUN whatever the operand values are. The FSM goes
// IDLE -> RUN -> DONE -> IDLE.
//
// Handshake: a start seen in IDLE at a rising edge is accepted, and a/b are
// captured on that same edge. busy is high for the WIDTH RUN cycles. done
// pulses for one cycle (the DONE state), and that is the cycle in which
// product first shows the new result. A start seen in RUN or DONE is
// ignored. There is no backpressure.
//
// Compile-time option:
//   SEQ_MUL_SIGNED_EN  When defined, a and b are two's-complement and product
//                      is the signed 2*WIDTH result. When undefined, the
//                      multiply is unsigned.
//
// Ports:
//   clk      in   1          clock; every state change is on the rising edge
//   rst      in   1          synchronous, active-high reset
//   start    in   1          request to begin a multiply
//   a        in   WIDTH      multiplicand (sampled only on an accepted start)
//   b        in   WIDTH      multiplier   (sampled only on an accepted start)
//   busy     out  1          high while in RUN
//   done     out  1          one-cycle pulse when product has been updated
//   product  out  2*WIDTH    result of the last completed multiply
// ----------------------------------------------------------------------------
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] sum;
    logic               last;
    logic [WIDTH-1:0]   a_op;
    logic [WIDTH-1:0]   b_op;

`ifdef SEQ_MUL_SIGNED_EN
    // Multiply the magnitudes and fix the sign at the end. -2^(WIDTH-1) has
    // magnitude 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    logic neg;
    assign a_op = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign b_op = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
`else
    assign a_op = a;
    assign b_op = b;
`endif

    // The partial product is the multiplicand shifted left by the bit index
    // and added at full 2*WIDTH width, so no carry is ever lost.
    assign partial = mplier[cnt] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    assign sum     = acc + partial;
    assign last    = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            acc     <= '0;
            product <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_op;
                        mplier <= b_op;
                        acc    <= '0;
                        cnt    <= '0;
`ifdef SEQ_MUL_SIGNED_EN
                        neg    <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    acc <= sum;
                    cnt <= cnt + CW'(1);
                    // The result goes to product on the same edge that enters
                    // DONE, so the sign fix costs no extra cycle.
                    if (last) begin
`ifdef SEQ_MUL_SIGNED_EN
                        product <= neg ? (~sum + (2*WIDTH)'(1)) : sum;
`else
                        product <= sum;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// ----------------------------------------------------------------------------
// tb_seq_mul -- directed testbench for seq_mul with WIDTH=8.
// Every expected value below is hand-computed.
// ----------------------------------------------------------------------------
module tb_seq_mul;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;

    int errors = 0;
    int checks = 0;

    seq_mul #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    // Advance one edge. Outputs are sampled 1 ns after the edge and inputs
    // are driven there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one multiply and check the latency, busy length, that product does
    // not move during RUN, the result, and that done is a single pulse.
    // If inj > 0, a spurious start with a=2, b=2 is driven during RUN cycle
    // inj. The operands are scrambled once the start has been accepted.
    task automatic run_mul(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [2*W-1:0] exp_p, input string name,
                           input int inj);
        logic [2*W-1:0] prev;
        int busy_cnt, lat, chg;
        bit seen;
        start = 1'b1; a = av; b = bv;
        step();
        start = 1'b0;
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        prev = product;
        busy_cnt = 0; lat = 0; chg = 0; seen = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin seen = 1; lat = k; break; end
            if (busy) busy_cnt++;
            if (product !== prev) chg++;
            if (k == inj) begin start = 1'b1; a = 8'd2; b = 8'd2; end
            else start = 1'b0;
            step();
        end
        start = 1'b0;
        checks++;
        if (!seen || lat != W + 1) begin
            errors++;
            $display("FAIL %s latency: seen=%0d cycle=%0d required cycle=%0d", name, seen, lat, W + 1);
        end
        checks++;
        if (busy_cnt != W) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, W);
        end
        checks++;
        if (chg != 0) begin
            errors++;
            $display("FAIL %s product_hold_in_run: changed %0d times required 0", name, chg);
        end
        checks++;
        if (product !== exp_p || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s result: product=%0h busy=%b required product=%0h busy=0", name, product, busy, exp_p);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== exp_p) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b product=%0h required 0 0 %0h", name, done, busy, product, exp_p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b product=%0h required 0 0 0", busy, done, product);
        end
        // A start in the same edge as reset must be ignored.
        start = 1'b1; a = 8'd3; b = 8'd3;
        step();
        rst = 1'b0; start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_max();
`ifdef SEQ_MUL_SIGNED_EN
        run_mul(8'hFF, 8'hFF, 16'h0001, "max_ff_ff", 0);   // -1 * -1
`else
        run_mul(8'hFF, 8'hFF, 16'hFE01, "max_ff_ff", 0);   // 255*255
`endif
    endtask

    task automatic test_back_to_back();
        run_mul(8'd13, 8'd11, 16'd143, "b2b_13x11", 0);
        run_mul(8'd0, 8'hA5, 16'd0, "b2b_0xa5", 0);
    endtask

    task automatic test_ignore_start();
        run_mul(8'd7, 8'd6, 16'd42, "ignore_start", 3);
    endtask

    task automatic test_abort();
        int pulses;
        start = 1'b1; a = 8'd200; b = 8'd3;
        step();
        start = 1'b0;
        step(); step(); step();            // now in RUN cycle 4
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b product=%0h required 0 0 0", busy, done, product);
        end
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) pulses++;
            step();
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_done: active cycles=%0d required 0", pulses);
        end
        run_mul(8'd5, 8'd5, 16'd25, "after_abort_5x5", 0);
    endtask

    task automatic test_signed();
`ifdef SEQ_MUL_SIGNED_EN
        run_mul(8'hFD, 8'h05, 16'hFFF1, "signed_m3x5", 0);
        run_mul(8'h80, 8'h80, 16'h4000, "signed_min_sq", 0);
`else
        run_mul(8'hFD, 8'h05, 16'h04F1, "unsigned_253x5", 0);
        run_mul(8'h80, 8'h80, 16'h4000, "unsigned_128sq", 0);
`endif
    endtask

    task automatic test_hold();
        int bad;
        run_mul(8'd9, 8'd9, 16'd81, "hold_9x9", 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (product !== 16'd81 || busy !== 1'b0 || done !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_after_done: bad cycles=%0d required 0 (product=%0h)", bad, product);
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        test_signed();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
